// File: rtl/if_id_ex_pipe_if.sv
// Bundle between the front-end pipeline registers and their surroundings.
// The slave side is the pipeline itself. The master side holds the hazard unit, instruction memory and debug bus.
interface if_id_ex_pipe_if #(
    parameter int CNT_W = 16
);
    // There is no valid/ready handshake here. Controls are sampled on every rising edge while run=1.
    // validD and validE mark whether a stage holds a real instruction or a bubble.
    // instr must be the memory word at pc within the same cycle.
    logic             run;
    logic             fStall;
    logic             dStall;
    logic             eFlush;
    logic             pcSrc;
    logic [31:0]      pcTarget;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [31:0]      IR;
    logic [31:0]      pcD;
    logic             validD;
    logic [31:0]      IR3;
    logic [31:0]      pcE;
    logic             validE;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output run, fStall, dStall, eFlush, pcSrc, pcTarget, instr,
        input  pc, IR, pcD, validD, IR3, pcE, validE, stallCnt, flushCnt
    );

    modport slave (
        input  run, fStall, dStall, eFlush, pcSrc, pcTarget, instr,
        output pc, IR, pcD, validD, IR3, pcE, validE, stallCnt, flushCnt
    );
endinterface

// File: rtl/if_id_ex_pipe.sv
// Front-end state of the 5-stage RV32 core: the PC register, the IF/ID register and the ID/EX register.
// It also keeps saturating stall and flush counters for the debug bus.
module if_id_ex_pipe #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP      = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input logic            clk,
    input logic            rst,
    if_id_ex_pipe_if.slave bus
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pcd_q, pcd_d;
    logic             vd_q, vd_d;
    logic [31:0]      ir3_q, ir3_d;
    logic [31:0]      pce_q, pce_d;
    logic             ve_q, ve_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        pcd_d       = pcd_q;
        vd_d        = vd_q;
        ir3_d       = ir3_q;
        pce_d       = pce_q;
        ve_d        = ve_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (bus.run) begin
            // A redirect overrides fStall, because the held fetch is on the wrong path.
            if (bus.pcSrc)       pc_d = bus.pcTarget;
            else if (!bus.fStall) pc_d = pc_q + 32'd4;

            if (bus.pcSrc) begin
                ir_d = NOP;
                vd_d = 1'b0;
            end else if (!bus.dStall) begin
                ir_d  = bus.instr;
                pcd_d = pc_q;
                vd_d  = 1'b1;
            end

            if (bus.eFlush || bus.pcSrc) begin
                ir3_d = NOP;
                ve_d  = 1'b0;
            end else begin
                ir3_d = ir_q;
                pce_d = pcd_q;
                ve_d  = vd_q;
            end

            if (bus.dStall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (bus.eFlush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= PC_RESET;
            ir_q        <= NOP;
            pcd_q       <= '0;
            vd_q        <= 1'b0;
            ir3_q       <= NOP;
            pce_q       <= '0;
            ve_q        <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            pcd_q       <= pcd_d;
            vd_q        <= vd_d;
            ir3_q       <= ir3_d;
            pce_q       <= pce_d;
            ve_q        <= ve_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.IR       = ir_q;
    assign bus.pcD      = pcd_q;
    assign bus.validD   = vd_q;
    assign bus.IR3      = ir3_q;
    assign bus.pcE      = pce_q;
    assign bus.validE   = ve_q;
    assign bus.stallCnt = stall_cnt_q;
    assign bus.flushCnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_ex_pipe.sv
// Bench for if_id_ex_pipe.
// Stimulus pushes predicted register snapshots into a queue, and a negedge monitor compares them against the DUT.
module tb_if_id_ex_pipe;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          CNT_W    = 16;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      ir;
        logic [31:0]      pcd;
        logic             vd;
        logic [31:0]      ir3;
        logic [31:0]      pce;
        logic             ve;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } snap_t;
    localparam int SW = $bits(snap_t);

    logic clk;
    logic rst;
    if_id_ex_pipe_if #(.CNT_W(CNT_W)) bus ();

    int checks   = 0;
    int failures = 0;
    logic [SW-1:0] exp_q[$];
    snap_t m;

    if_id_ex_pipe #(.PC_RESET(PC_RESET), .NOP(NOP), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory model: the word at address a is a + 0x100.
    assign bus.instr = bus.pc + 32'h100;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Driver: applies one cycle of inputs, steps the reference model and queues the expected snapshot.
    task automatic cycle(input logic r, input logic rn, input logic fs, input logic ds,
                         input logic ef, input logic ps, input logic [31:0] tgt);
        snap_t n;
        @(negedge clk);
        rst = r; bus.run = rn; bus.fStall = fs; bus.dStall = ds;
        bus.eFlush = ef; bus.pcSrc = ps; bus.pcTarget = tgt;
        n = m;
        if (r) begin
            n = '{pc: PC_RESET, ir: NOP, pcd: 32'h0, vd: 1'b0, ir3: NOP, pce: 32'h0,
                  ve: 1'b0, sc: '0, fc: '0};
        end else if (rn) begin
            if (ps) n.pc = tgt;
            else if (!fs) n.pc = m.pc + 32'd4;
            if (ps) begin
                n.ir = NOP; n.vd = 1'b0;
            end else if (!ds) begin
                n.ir = m.pc + 32'h100; n.pcd = m.pc; n.vd = 1'b1;
            end
            if (ef || ps) begin
                n.ir3 = NOP; n.ve = 1'b0;
            end else begin
                n.ir3 = m.ir; n.pce = m.pcd; n.ve = m.vd;
            end
            if (ds && m.sc != {CNT_W{1'b1}}) n.sc = m.sc + 1'b1;
            if (ef && m.fc != {CNT_W{1'b1}}) n.fc = m.fc + 1'b1;
        end
        @(posedge clk);
        m = n;
        exp_q.push_back(n);
    endtask

    task automatic run_plain(input logic fs, input logic ds, input logic ef,
                             input logic ps, input logic [31:0] tgt);
        cycle(1'b0, 1'b1, fs, ds, ef, ps, tgt);
        #2;
    endtask

    // Monitor: checks every queued snapshot against the DUT outputs.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc", bus.pc, e.pc);
                chk("IR", bus.IR, e.ir);
                chk("pcD", bus.pcD, e.pcd);
                chk("validD", {31'b0, bus.validD}, {31'b0, e.vd});
                chk("IR3", bus.IR3, e.ir3);
                chk("pcE", bus.pcE, e.pce);
                chk("validE", {31'b0, bus.validE}, {31'b0, e.ve});
                chk("stallCnt", {16'b0, bus.stallCnt}, {16'b0, e.sc});
                chk("flushCnt", {16'b0, bus.flushCnt}, {16'b0, e.fc});
            end
        end
    end

    initial begin
        m = '0;
        rst = 1'b1; bus.run = 1'b0; bus.fStall = 1'b0; bus.dStall = 1'b0;
        bus.eFlush = 1'b0; bus.pcSrc = 1'b0; bus.pcTarget = 32'h0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("rst_pc", bus.pc, 32'h3000);
        chk("rst_IR", bus.IR, 32'h13);
        chk("rst_IR3", bus.IR3, 32'h13);
        chk("rst_validD", {31'b0, bus.validD}, 32'h0);

        // Free run: IR trails pc by one edge, IR3 by two
        run_plain(0, 0, 0, 0, 32'h0);
        chk("run1_pc", bus.pc, 32'h3004);
        chk("run1_IR", bus.IR, 32'h3100);
        chk("run1_validD", {31'b0, bus.validD}, 32'h1);
        chk("run1_validE", {31'b0, bus.validE}, 32'h0);
        run_plain(0, 0, 0, 0, 32'h0);
        chk("run2_pc", bus.pc, 32'h3008);
        chk("run2_IR3", bus.IR3, 32'h3100);
        chk("run2_validE", {31'b0, bus.validE}, 32'h1);
        run_plain(0, 0, 0, 0, 32'h0);
        chk("run3_pc", bus.pc, 32'h300C);
        chk("run3_IR", bus.IR, 32'h3108);

        // Load-use bubble
        run_plain(1, 1, 1, 0, 32'h0);
        chk("lu_pc", bus.pc, 32'h300C);
        chk("lu_IR", bus.IR, 32'h3108);
        chk("lu_IR3", bus.IR3, 32'h13);
        chk("lu_validE", {31'b0, bus.validE}, 32'h0);
        chk("lu_stallCnt", {16'b0, bus.stallCnt}, 32'h1);
        chk("lu_flushCnt", {16'b0, bus.flushCnt}, 32'h1);
        run_plain(0, 0, 0, 0, 32'h0);
        chk("lu_next_IR3", bus.IR3, 32'h3108);
        chk("lu_next_pc", bus.pc, 32'h3010);
        chk("lu_next_IR", bus.IR, 32'h310C);

        // Redirect beats fStall and dStall
        run_plain(1, 1, 0, 1, 32'h3040);
        chk("rd_pc", bus.pc, 32'h3040);
        chk("rd_IR", bus.IR, 32'h13);
        chk("rd_validD", {31'b0, bus.validD}, 32'h0);
        chk("rd_IR3", bus.IR3, 32'h13);
        chk("rd_validE", {31'b0, bus.validE}, 32'h0);
        run_plain(0, 0, 0, 0, 32'h0);
        chk("rd_next_IR", bus.IR, 32'h3140);
        chk("rd_next_pcD", bus.pcD, 32'h3040);
        chk("rd_next_pc", bus.pc, 32'h3044);

        // run=0 freezes everything
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
        #2;
        chk("frz_pc", bus.pc, 32'h3044);
        chk("frz_IR", bus.IR, 32'h3140);
        chk("frz_stallCnt", {16'b0, bus.stallCnt}, 32'h2);
        chk("frz_flushCnt", {16'b0, bus.flushCnt}, 32'h1);

        // PC wrap
        run_plain(0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_pre_pc", bus.pc, 32'hFFFF_FFFC);
        run_plain(0, 0, 0, 0, 32'h0);
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_pcD", bus.pcD, 32'hFFFF_FFFC);

        // Stall counter saturation
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        #2;
        chk("sat_stallCnt", {16'b0, bus.stallCnt}, 32'hFFFF);
        chk("sat_flushCnt", {16'b0, bus.flushCnt}, 32'h1);

        // Reset mid-stream with dStall and pcSrc asserted
        run_plain(0, 0, 1, 0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5000);
        #2;
        chk("mrst_pc", bus.pc, 32'h3000);
        chk("mrst_IR3", bus.IR3, 32'h13);
        chk("mrst_pcD", bus.pcD, 32'h0);
        chk("mrst_validE", {31'b0, bus.validE}, 32'h0);
        chk("mrst_stallCnt", {16'b0, bus.stallCnt}, 32'h0);
        chk("mrst_flushCnt", {16'b0, bus.flushCnt}, 32'h0);
        run_plain(0, 0, 0, 0, 32'h0);
        chk("post_rst_pc", bus.pc, 32'h3004);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
